// File: rtl/bus_fabric_pkg.sv
// bus_fabric_pkg: FSM states, fault-cause codes and sizing helper shared by the bus fabric.
package bus_fabric_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;
  localparam logic [1:0] FC_MISS  = 2'd0;
  localparam logic [1:0] FC_SLV   = 2'd1;
  localparam logic [1:0] FC_TMO   = 2'd2;
  localparam logic [1:0] FC_PROT  = 2'd3;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: priority address decoder, lowest-index hit wins; reports one-hot grant, index and miss.
module bus_addr_decode
  import bus_fabric_pkg::*;
#(
  parameter int N_SLV = 7,
  parameter int XLEN  = 32,
  parameter int SEL_W = idx_w(N_SLV),
  parameter logic [N_SLV*XLEN-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*XLEN-1:0] SLV_MASK = '0
) (
  input  logic [XLEN-1:0]  addr,
  output logic [N_SLV-1:0] grant,
  output logic [SEL_W-1:0] idx,
  output logic             miss
);
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--)
      if ((addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN]) begin
        grant = '0;
        grant[i] = 1'b1;
        idx = SEL_W'(i);
      end
  end
  assign miss = ~|grant;
endmodule

// File: rtl/bus_fabric.sv
// bus_fabric: single-master fabric routing req/resp/rdata by address map, with outstanding
// tracking, response timeout, protocol checking and a sticky fault record.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int N_SLV     = 7,
  parameter int XLEN      = 32,
  parameter int BUS_WIDTH = 32,
  parameter int ACC_W     = 2,
  parameter logic [N_SLV*XLEN-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*XLEN-1:0] SLV_MASK = '0,
  parameter int TIMEOUT   = 256
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [XLEN-1:0]            bus_addr,
  input  logic                       bus_w_rb,
  input  logic [ACC_W-1:0]           bus_acc,
  input  logic [BUS_WIDTH-1:0]       bus_wdata,
  input  logic                       bus_req,
  output logic                       bus_resp,
  output logic [BUS_WIDTH-1:0]       bus_rdata,
  output logic [N_SLV-1:0]           s_req,
  input  logic [N_SLV-1:0]           s_resp,
  input  logic [N_SLV*BUS_WIDTH-1:0] s_rdata,
  input  logic [N_SLV-1:0]           s_fault,
  output logic                       fault,
  output logic [1:0]                 fault_code,
  output logic [XLEN-1:0]            fault_addr,
  output logic                       busy
);
  localparam int SEL_W = idx_w(N_SLV);
  logic [1:0] state_q, state_d, fault_code_q, fault_code_d, code;
  logic [SEL_W-1:0] sel_q, sel_d, idx;
  logic [XLEN-1:0] addr_q, addr_d, fault_addr_q, fault_addr_d;
  logic [31:0] cnt_q, cnt_d;
  logic fault_q, fault_d;
  logic [N_SLV-1:0] grant;
  logic miss, in_idle, in_wait, any_sf, sel_resp, resp_sel, accept, start;
  logic prot, tmo_hit, go_fault, unused_bcast;
  // Write-side signals fan out to the slaves at the SoC level; the fabric only carries them.
  assign unused_bcast = ^{bus_w_rb, bus_acc, bus_wdata};
  bus_addr_decode #(
    .N_SLV(N_SLV), .XLEN(XLEN), .SEL_W(SEL_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_dec (
    .addr(bus_addr), .grant(grant), .idx(idx), .miss(miss)
  );
  assign in_idle  = state_q == ST_IDLE;
  assign in_wait  = state_q == ST_WAIT;
  assign any_sf   = |s_fault;
  assign sel_resp = s_resp[sel_q];
  assign resp_sel = in_wait && sel_resp;
  assign accept   = bus_req && !any_sf && (in_idle || resp_sel);
  assign start    = accept && !miss;
  assign prot     = in_wait && bus_req && !sel_resp;
  // Timeout fires when the counter steps onto TIMEOUT-1, so the fault lands TIMEOUT cycles after the request.
  assign tmo_hit  = in_wait && !bus_req && !sel_resp && TIMEOUT != 0 && cnt_q + 32'd2 >= 32'(TIMEOUT);
  assign go_fault = !(state_q == ST_FAULT) && (any_sf || prot || tmo_hit || (accept && miss));
  assign code     = any_sf ? FC_SLV : prot ? FC_PROT : tmo_hit ? FC_TMO : FC_MISS;
  assign s_req     = start ? grant : '0;
  assign bus_resp  = resp_sel && !any_sf;
  assign bus_rdata = bus_resp ? s_rdata[sel_q*BUS_WIDTH +: BUS_WIDTH] : '0;
  assign busy       = in_wait;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign fault_addr = fault_addr_q;
  always_comb begin
    state_d      = go_fault ? ST_FAULT : start ? ST_WAIT : resp_sel ? ST_IDLE : state_q;
    sel_d        = start ? idx : sel_q;
    addr_d       = start ? bus_addr : addr_q;
    cnt_d        = start ? '0 : in_wait ? cnt_q + 32'd1 : cnt_q;
    fault_d      = fault_q | go_fault;
    fault_code_d = go_fault ? code : fault_code_q;
    fault_addr_d = !go_fault ? fault_addr_q : (in_wait && (any_sf || tmo_hit)) ? addr_q : bus_addr;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_MISS;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      fault_addr_q <= fault_addr_d;
    end
  end
endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: directed scenarios on a 3-slave map (0x0000/0x1000/0x2000, mask 0xF000, timeout 4).
module tb_bus_fabric;
  localparam int N = 3;
  logic clk = 1'b0, rstn = 1'b0;
  logic [31:0] bus_addr = '0, bus_wdata = '0, bus_rdata, fault_addr;
  logic bus_w_rb = 1'b0, bus_req = 1'b0, bus_resp, fault, busy;
  logic [1:0] bus_acc = '0, fault_code;
  logic [N-1:0] s_req, s_resp = '0, s_fault = '0;
  logic [N*32-1:0] s_rdata = '0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  bus_fabric #(
    .N_SLV(3), .XLEN(32), .BUS_WIDTH(32), .ACC_W(2),
    .SLV_BASE({32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .SLV_MASK({32'h0000_F000, 32'h0000_F000, 32'h0000_F000}),
    .TIMEOUT(4)
  ) dut (
    .clk(clk), .rstn(rstn), .bus_addr(bus_addr), .bus_w_rb(bus_w_rb), .bus_acc(bus_acc),
    .bus_wdata(bus_wdata), .bus_req(bus_req), .bus_resp(bus_resp), .bus_rdata(bus_rdata),
    .s_req(s_req), .s_resp(s_resp), .s_rdata(s_rdata), .s_fault(s_fault), .fault(fault),
    .fault_code(fault_code), .fault_addr(fault_addr), .busy(busy)
  );
  task tick;
    @(posedge clk);
    #1;
  endtask
  task idle_inputs;
    bus_req = 1'b0; bus_addr = '0; s_resp = '0; s_fault = '0; s_rdata = '0;
  endtask
  task do_reset;
    idle_inputs();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask
  task test_reset;
    idle_inputs();
    rstn = 1'b0;
    #2;
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault got %b exp 0", fault); end
    n_vec++; if (fault_code !== 2'd0) begin n_err++; $display("FAIL rst_code got %0d exp 0", fault_code); end
    n_vec++; if (fault_addr !== 32'h0) begin n_err++; $display("FAIL rst_faddr got %h exp 0", fault_addr); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_vec++; if (bus_resp !== 1'b0) begin n_err++; $display("FAIL rst_resp got %b exp 0", bus_resp); end
    n_vec++; if (s_req !== 3'b000) begin n_err++; $display("FAIL rst_sreq got %b exp 000", s_req); end
    n_vec++; if (bus_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h exp 0", bus_rdata); end
    tick();
    rstn = 1'b1;
  endtask
  task test_read;
    tick(); bus_addr = 32'h1004; bus_req = 1'b1; #1;
    n_vec++; if (s_req !== 3'b010) begin n_err++; $display("FAIL read_sreq got %b exp 010", s_req); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL read_busy0 got %b exp 0", busy); end
    tick(); bus_req = 1'b0; s_resp = 3'b001; s_rdata[0 +: 32] = 32'h1111_1111; #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL read_busy1 got %b exp 1", busy); end
    n_vec++; if (bus_resp !== 1'b0) begin n_err++; $display("FAIL read_unsel_resp got %b exp 0", bus_resp); end
    n_vec++; if (bus_rdata !== 32'h0) begin n_err++; $display("FAIL read_unsel_rdata got %h exp 0", bus_rdata); end
    tick(); s_resp = 3'b010; s_rdata[32 +: 32] = 32'hDEAD_BEEF; #1;
    n_vec++; if (bus_resp !== 1'b1) begin n_err++; $display("FAIL read_resp got %b exp 1", bus_resp); end
    n_vec++; if (bus_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL read_rdata got %h exp deadbeef", bus_rdata); end
    tick(); idle_inputs(); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL read_idle_busy got %b exp 0", busy); end
    n_vec++; if (bus_resp !== 1'b0) begin n_err++; $display("FAIL read_idle_resp got %b exp 0", bus_resp); end
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL read_fault got %b exp 0", fault); end
  endtask
  task test_back_to_back;
    tick(); bus_addr = 32'h0000; bus_req = 1'b1; #1;
    n_vec++; if (s_req !== 3'b001) begin n_err++; $display("FAIL b2b_sreq0 got %b exp 001", s_req); end
    tick(); s_resp = 3'b001; s_rdata[0 +: 32] = 32'hCAFE_0000; bus_addr = 32'h2000; bus_req = 1'b1; #1;
    n_vec++; if (s_req !== 3'b100) begin n_err++; $display("FAIL b2b_sreq2 got %b exp 100", s_req); end
    n_vec++; if (bus_resp !== 1'b1) begin n_err++; $display("FAIL b2b_resp0 got %b exp 1", bus_resp); end
    n_vec++; if (bus_rdata !== 32'hCAFE_0000) begin n_err++; $display("FAIL b2b_rdata0 got %h exp cafe0000", bus_rdata); end
    tick(); idle_inputs(); #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b exp 1", busy); end
    n_vec++; if (bus_resp !== 1'b0) begin n_err++; $display("FAIL b2b_gap_resp got %b exp 0", bus_resp); end
    tick(); s_resp = 3'b100; s_rdata[64 +: 32] = 32'h2222_2222; #1;
    n_vec++; if (bus_resp !== 1'b1) begin n_err++; $display("FAIL b2b_resp2 got %b exp 1", bus_resp); end
    n_vec++; if (bus_rdata !== 32'h2222_2222) begin n_err++; $display("FAIL b2b_rdata2 got %h exp 22222222", bus_rdata); end
    tick(); idle_inputs(); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_end_busy got %b exp 0", busy); end
  endtask
  task test_slave_fault;
    tick(); bus_addr = 32'h1000; bus_req = 1'b1; #1;
    n_vec++; if (s_req !== 3'b010) begin n_err++; $display("FAIL sf_sreq got %b exp 010", s_req); end
    tick(); bus_req = 1'b0; s_resp = 3'b010; s_fault = 3'b010; s_rdata[32 +: 32] = 32'h1234_5678; #1;
    n_vec++; if (bus_resp !== 1'b0) begin n_err++; $display("FAIL sf_resp got %b exp 0", bus_resp); end
    n_vec++; if (bus_rdata !== 32'h0) begin n_err++; $display("FAIL sf_rdata got %h exp 0", bus_rdata); end
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL sf_early got %b exp 0", fault); end
    tick(); idle_inputs(); bus_addr = 32'h1000; bus_req = 1'b1; #1;
    n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL sf_fault got %b exp 1", fault); end
    n_vec++; if (fault_code !== 2'd1) begin n_err++; $display("FAIL sf_code got %0d exp 1", fault_code); end
    n_vec++; if (fault_addr !== 32'h1000) begin n_err++; $display("FAIL sf_faddr got %h exp 1000", fault_addr); end
    n_vec++; if (s_req !== 3'b000) begin n_err++; $display("FAIL sf_sticky_sreq got %b exp 000", s_req); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sf_busy got %b exp 0", busy); end
    do_reset();
  endtask
  task test_protocol;
    tick(); bus_addr = 32'h2008; bus_req = 1'b1; #1;
    n_vec++; if (s_req !== 3'b100) begin n_err++; $display("FAIL prot_sreq got %b exp 100", s_req); end
    tick(); bus_addr = 32'h0000; bus_req = 1'b1; #1;
    n_vec++; if (s_req !== 3'b000) begin n_err++; $display("FAIL prot_sreq2 got %b exp 000", s_req); end
    tick(); idle_inputs(); #1;
    n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL prot_fault got %b exp 1", fault); end
    n_vec++; if (fault_code !== 2'd3) begin n_err++; $display("FAIL prot_code got %0d exp 3", fault_code); end
    n_vec++; if (fault_addr !== 32'h0000) begin n_err++; $display("FAIL prot_faddr got %h exp 0", fault_addr); end
    do_reset();
  endtask
  task test_timeout;
    tick(); bus_addr = 32'h0010; bus_req = 1'b1; #1;
    n_vec++; if (s_req !== 3'b001) begin n_err++; $display("FAIL tmo_sreq got %b exp 001", s_req); end
    tick(); idle_inputs();
    tick();
    tick(); #1;
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL tmo_early got %b exp 0", fault); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL tmo_busy got %b exp 1", busy); end
    tick(); s_resp = 3'b001; s_rdata[0 +: 32] = 32'hAAAA_5555; #1;
    n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL tmo_fault got %b exp 1", fault); end
    n_vec++; if (fault_code !== 2'd2) begin n_err++; $display("FAIL tmo_code got %0d exp 2", fault_code); end
    n_vec++; if (fault_addr !== 32'h0010) begin n_err++; $display("FAIL tmo_faddr got %h exp 10", fault_addr); end
    n_vec++; if (bus_resp !== 1'b0) begin n_err++; $display("FAIL tmo_late_resp got %b exp 0", bus_resp); end
    n_vec++; if (bus_rdata !== 32'h0) begin n_err++; $display("FAIL tmo_late_rdata got %h exp 0", bus_rdata); end
    do_reset();
  endtask
  task test_miss;
    tick(); bus_addr = 32'h9000; bus_req = 1'b1; #1;
    n_vec++; if (s_req !== 3'b000) begin n_err++; $display("FAIL miss_sreq got %b exp 000", s_req); end
    tick(); idle_inputs(); #1;
    n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL miss_fault got %b exp 1", fault); end
    n_vec++; if (fault_code !== 2'd0) begin n_err++; $display("FAIL miss_code got %0d exp 0", fault_code); end
    n_vec++; if (fault_addr !== 32'h9000) begin n_err++; $display("FAIL miss_faddr got %h exp 9000", fault_addr); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL miss_busy got %b exp 0", busy); end
    tick(); bus_addr = 32'h1000; bus_req = 1'b1; #1;
    n_vec++; if (s_req !== 3'b000) begin n_err++; $display("FAIL miss_ignored got %b exp 000", s_req); end
    n_vec++; if (fault_addr !== 32'h9000) begin n_err++; $display("FAIL miss_sticky got %h exp 9000", fault_addr); end
    do_reset();
  endtask
  task test_reset_mid;
    tick(); bus_addr = 32'h1000; bus_req = 1'b1; #1;
    n_vec++; if (s_req !== 3'b010) begin n_err++; $display("FAIL rm_sreq got %b exp 010", s_req); end
    tick(); bus_req = 1'b0; #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rm_busy got %b exp 1", busy); end
    rstn = 1'b0; #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_async_busy got %b exp 0", busy); end
    n_vec++; if (s_req !== 3'b000) begin n_err++; $display("FAIL rm_async_sreq got %b exp 000", s_req); end
    tick(); rstn = 1'b1; s_resp = 3'b010; s_rdata[32 +: 32] = 32'hBAD0_BAD0; #1;
    n_vec++; if (bus_resp !== 1'b0) begin n_err++; $display("FAIL rm_stale_resp got %b exp 0", bus_resp); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_stale_busy got %b exp 0", busy); end
    tick(); idle_inputs(); bus_addr = 32'h0004; bus_req = 1'b1; #1;
    n_vec++; if (s_req !== 3'b001) begin n_err++; $display("FAIL rm_new_sreq got %b exp 001", s_req); end
    tick(); bus_req = 1'b0; s_resp = 3'b001; s_rdata[0 +: 32] = 32'h600D_F00D; #1;
    n_vec++; if (bus_resp !== 1'b1) begin n_err++; $display("FAIL rm_new_resp got %b exp 1", bus_resp); end
    n_vec++; if (bus_rdata !== 32'h600D_F00D) begin n_err++; $display("FAIL rm_new_rdata got %h exp 600df00d", bus_rdata); end
    tick(); idle_inputs(); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_end_busy got %b exp 0", busy); end
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL rm_fault got %b exp 0", fault); end
  endtask
  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_slave_fault();
    test_protocol();
    test_timeout();
    test_miss();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bus_fabric.md
# bus_fabric

Parametrised single-master bus fabric that replaces hand-written per-peripheral select, response-mux and fault-OR logic at the SoC top level. It sits between `core` and N peripheral controllers. It decodes each request against a parameter-supplied address map and routes `req`, `resp` and `rdata`. It also adds what the fixed-decode version lacks: outstanding-transaction tracking, a response timeout, protocol checking and a sticky fault record (cause plus address).

## Interface
- `N_SLV`, 7: number of slave channels (1..16).
- `XLEN`, 32: address width.
- `BUS_WIDTH`, 32: data width.
- `ACC_W`, 2: width of `acc` (`$clog2(BUS_ACC_CNT)`).
- `SLV_BASE`, 0: `N_SLV*XLEN` flattened base addresses; channel i occupies bits `[i*XLEN +: XLEN]`.
- `SLV_MASK`, 0: `N_SLV*XLEN` flattened select masks, same layout.
- `TIMEOUT`, 256: cycles allowed in WAIT before a timeout fault; 0 disables the timeout.

Ports:
- `clk` in 1: the single clock.
- `rstn` in 1: asynchronous active-low reset.
- `bus_addr` in XLEN: master address.
- `bus_w_rb` in 1: master write/read-bar, broadcast to all slaves.
- `bus_acc` in ACC_W: master access size, broadcast.
- `bus_wdata` in BUS_WIDTH: master write data, broadcast.
- `bus_req` in 1: master request pulse.
- `bus_resp` out 1: response to the master.
- `bus_rdata` out BUS_WIDTH: read data to the master.
- `s_req` out N_SLV: per-slave request.
- `s_resp` in N_SLV: per-slave response.
- `s_rdata` in N_SLV*BUS_WIDTH: flattened per-slave read data.
- `s_fault` in N_SLV: per-slave fault.
- `fault` out 1: sticky fault flag; drives the core halt.
- `fault_code` out 2: fault cause. 0 = decode miss, 1 = slave fault, 2 = timeout, 3 = protocol violation.
- `fault_addr` out XLEN: `bus_addr` of the transaction that faulted.
- `busy` out 1: high while a transaction is outstanding.

## Operation
Decode:
- `hit[i] = (bus_addr & mask_i) == base_i`.
- The grant is the lowest-index hit (priority, one-hot).
- `miss` = no hit.

FSM states: IDLE, WAIT, FAULT.

IDLE:
- `bus_req` with a hit: `s_req[g]` is driven high the same cycle (combinational). `sel <= g`, `addr_q <= bus_addr`, counter cleared, next state WAIT.
- `bus_req` with a miss: no `s_req` is driven; the fabric enters FAULT with code 0.

WAIT:
- `bus_resp = s_resp[sel]` and `bus_rdata = s_rdata[sel]`.
- The counter increments each cycle.
- On `s_resp[sel]` the state returns to IDLE, unless `bus_req` is high the same cycle. That back-to-back request is decoded as in IDLE, and the state stays in WAIT with the new `sel`.
- `bus_req` without `s_resp[sel]`: FAULT, code 3.
- Counter reaches `TIMEOUT-1` with no response (when `TIMEOUT` ≠ 0): FAULT, code 2.

FAULT:
- Sticky; left only by reset.
- All `s_req` are 0, `bus_resp` is 0, and `bus_req` is ignored.

Slave faults:
- Any `s_fault` bit high in IDLE or WAIT sends the fabric to FAULT with code 1.
- `s_resp` in that same cycle is suppressed: `bus_resp` stays 0.

Fault priority when several causes occur in one cycle: slave fault > protocol > timeout > decode miss.

Other rules:
- `s_resp` from an unselected channel is ignored.
- `bus_rdata` is 0 whenever `bus_resp` is 0.
- `busy` is high exactly in WAIT.

## Timing
- Reset values: state IDLE, `sel` 0, counter 0, `fault` 0, `fault_code` 0, `fault_addr` 0, `busy` 0, `bus_resp` 0, `s_req` 0.
- Request path: zero latency, combinational from `bus_req`/`bus_addr`. The fabric adds no cycles.
- Slaves respond at the earliest one cycle after `s_req`. The response path is combinational from `s_resp`/`s_rdata`.
- `fault`, `fault_code` and `fault_addr` are registered: they become valid the cycle after the causing event.
- `fault_addr` records the request's address, or `addr_q` for timeout and slave faults seen in WAIT.
- A timeout fault is registered `TIMEOUT` cycles after the request cycle.
- Reset asserted mid-transaction: everything returns to reset values immediately (asynchronous). An outstanding slave response arriving after reset release is ignored, because the state is IDLE.

## Structure
- Fault-code constants and the default address map (per-channel BASE/MASK pairs) go in `femto.vh` beside the existing select masks.
- One sub-module, `bus_addr_decode`: combinational priority decoder producing the one-hot grant and `miss` from the address and the parameter arrays.
- The FSM, the counter, the fault record and the response mux stay in `bus_fabric`.

## Test plan
- `N_SLV`=3, bases 0x0000/0x1000/0x2000, masks 0xF000. Read 0x1004 with slave 1 responding `rdata`=0xDEADBEEF after 2 cycles: `s_req`=3'b010 on the request cycle, then `bus_resp`=1 with `bus_rdata`=0xDEADBEEF, then IDLE.
- Back-to-back: request 0x0000, then request 0x2000 issued in the cycle slave 0 responds: `s_req`=3'b100 that cycle, `busy` stays 1, and slave 2's data is returned next.
- Request to 0x9000: no `s_req`; next cycle `fault`=1, `fault_code`=0, `fault_addr`=0x9000; later `bus_req` pulses are ignored.
- `TIMEOUT`=4, slave 0 silent: `fault`=1 with code 2 four cycles after the request. A late `s_resp[0]` yields `bus_resp`=0.
- `s_fault[1]` coincident with `s_resp[1]`: `bus_resp`=0, code 1. A second `bus_req` in WAIT before any response gives code 3.
- `rstn` pulsed low during WAIT: all outputs return to reset values at once, and a fresh request completes normally after reset release.
